clk_gen_multi: RTL and testbench
================================

# clk_gen_multi

Multi-channel programmable clock/tick generator for the calculator's slow-clock domain: display multiplexing, debounce sampling and blink timing. Each of `CHANNELS` independent channels divides `clk` by a runtime-programmable divisor and produces a registered square or duty-programmable output plus a one-cycle tick. Divisor updates arrive over a valid/ready config port and take effect only at a period boundary, so no output ever emits a glitch or runt period. It supersedes the single fixed-divisor divider, which could only produce periods of 2n.

## Interface
- `CHANNELS`, 4: number of independent output channels (1..16).
- `CNT_W`, 32: counter and divisor width.
- `DEFAULT_DIV`, 50000000: divisor loaded into every channel on reset (≥2).
- `clk`  in  1: system clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `en`  in  CHANNELS: per-channel run enable.
- `cfg_valid`  in  1: config request.
- `cfg_ready`  out  1: config can be accepted for channel `cfg_ch`.
- `cfg_ch`  in  $clog2(CHANNELS) (min 1): target channel.
- `cfg_div`  in  CNT_W: new divisor (output period in `clk` cycles).
- `cfg_high`  in  CNT_W: high-phase length. Present only with `CLK_GEN_DUTY_EN`.
- `clk_out`  out  CHANNELS: divided outputs, registered.
- `tick`  out  CHANNELS: one-cycle pulse at the start of each period, registered.

## Operation
- Per-channel state:
  - `count` (phase, 0..div−1).
  - `div_act`, and `high_act` when the macro is defined.
  - Shadow `div_sh`/`high_sh`.
  - `pending` flag.
- Reset values:
  - `count` = DEFAULT_DIV−1, `div_act` = `div_sh` = DEFAULT_DIV.
  - `high_act` = `high_sh` = DEFAULT_DIV>>1.
  - `pending` = 0, `clk_out` = 0, `tick` = 0.
- Running (`en[i]` = 1): `count_next` = 0 if `count` == `div_act`−1, else `count`+1.
  - `clk_out[i]` <= (`count_next` < `high_act`).
  - `tick[i]` <= (`count_next` == 0).
- Disabled (`en[i]` = 0): `count` <= `div_act`−1, `clk_out[i]` <= 0, `tick[i]` <= 0. The first enabled edge enters phase 0, with `clk_out` and `tick` both 1.
- Clamping:
  - At accept, `cfg_div` < 2 is stored as 2.
  - At apply, the high phase is clamped to [1, div−1].
- `cfg_ready` = ~`pending[cfg_ch]` (combinational). An out-of-range `cfg_ch` gives `cfg_ready` = 1; the transfer is accepted and discarded.
- On accept (`cfg_valid` & `cfg_ready`): write the shadow registers and set `pending`.
- Apply: when `pending` and (the channel wraps this edge or `en` = 0), then `div_act`/`high_act` <= shadow, `pending` <= 0, and `count` <= 0 (or new_div−1 if disabled). The old period always completes in full.
- A second write to the same channel stalls until the apply. Writes to other channels are unaffected.
- `rst` mid-period or mid-pending discards the shadow and reverts to DEFAULT_DIV.

## Timing
- Output period = `div_act` cycles exactly; high phase = `high_act` cycles.
- `clk_out` and `tick` are registered and aligned: `tick` is high in the first high cycle of each period.
- Config latency: from accept to the first period with the new divisor = the remaining cycles of the current period + 1. If the channel is disabled, the new divisor applies on the edge after the accept.
- Outputs are intended as logic-rate clocks/enables. They are not to be used for clock gating.

## Configuration
- `CLK_GEN_DUTY_EN` defined: adds the `cfg_high` port and `high_sh`/`high_act` registers; duty is programmable with clamping.
- Without it: no `cfg_high` port. `high_act` = `div_act`>>1, giving 50% duty for even divisors and a high phase one cycle shorter than the low phase for odd divisors.

## Structure
- Package `clk_gen_pkg` holds:
  - The `CNT_W` default and the `MIN_DIV` = 2 constant.
  - The divisor/high clamp function.
  - A channel-config struct (div, high).
- One sub-module, `clk_gen_chan`: counter, shadow/pending logic and output registers. The top level instantiates `CHANNELS` copies and decodes `cfg_ch`/`cfg_ready`.

## Test plan
- DEFAULT_DIV = 4, `en` = 1 after reset: `clk_out` = 1,1,0,0 repeating, period 4; `tick` high on each rising cycle of `clk_out`.
- Write `cfg_div` = 6 to ch1 mid-period: `cfg_ready` drops until the current 4-cycle period ends, then the channel runs period 6. ch0 is undisturbed.
- `cfg_div` = 0 and `cfg_div` = 1: the channel runs period 2 (1 high, 1 low).
- Drop `en[2]` mid-period for 10 cycles, then raise it: output is 0 while disabled; on re-enable the first cycle has `clk_out` = 1 and `tick` = 1.
- With `CLK_GEN_DUTY_EN`: `cfg_div` = 10, `cfg_high` = 3 gives 3 high / 7 low. `cfg_high` = 0 gives 1 high; `cfg_high` = 12 gives 9 high.
- Assert `rst` while ch3 is pending with div 8: after release, all channels run at DEFAULT_DIV, `pending` = 0, and `cfg_ready` = 1.

Source files
------------

// File: rtl/clk_gen_pkg.sv
// Shared constants, per-channel config struct and clamp helpers for clk_gen_multi.
// The optional CLK_GEN_DUTY_EN build uses chan_cfg_t and clamp_cfg for programmable duty.
package clk_gen_pkg;

  localparam int CNT_W_DEF = 32;
  localparam logic [CNT_W_DEF-1:0] MIN_DIV = CNT_W_DEF'(2);

  typedef struct packed {
    logic [CNT_W_DEF-1:0] div;
    logic [CNT_W_DEF-1:0] high;
  } chan_cfg_t;

  function automatic logic [CNT_W_DEF-1:0] clamp_div(input logic [CNT_W_DEF-1:0] div);
    return (div < MIN_DIV) ? MIN_DIV : div;
  endfunction

  // Keeps at least one high and one low cycle in every period.
  function automatic chan_cfg_t clamp_cfg(input chan_cfg_t cfg);
    chan_cfg_t res;
    res = cfg;
    if (cfg.high == '0)
      res.high = CNT_W_DEF'(1);
    else if (cfg.high >= cfg.div)
      res.high = cfg.div - 1'b1;
    return res;
  endfunction

endpackage

// File: rtl/clk_gen_chan.sv
// One divider channel: phase counter, shadow/pending divisor update and output registers.
// Duty programmability (high_i, high shadow/active registers) exists only with CLK_GEN_DUTY_EN.
module clk_gen_chan
  import clk_gen_pkg::*;
#(
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             acc_i,
  input  logic [CNT_W-1:0] div_i,
`ifdef CLK_GEN_DUTY_EN
  input  logic [CNT_W-1:0] high_i,
`endif
  output logic             pend_o,
  output logic             clk_out_o,
  output logic             tick_o
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] count_q, count_d, count_inc;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] div_sh_q, div_sh_d;
  logic [CNT_W-1:0] high_act;
  logic             pend_q, pend_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             wrap, apply;

`ifdef CLK_GEN_DUTY_EN
  localparam logic [CNT_W-1:0] HIGH_RST = DIV_RST >> 1;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] high_sh_q, high_sh_d;
  chan_cfg_t        cfg_new;
`endif

  always_comb begin
    div_sh_d  = div_sh_q;
    div_d     = div_q;
    pend_d    = pend_q;
    count_d   = count_q;
    clk_out_d = 1'b0;
    tick_d    = 1'b0;
`ifdef CLK_GEN_DUTY_EN
    high_sh_d = high_sh_q;
    high_d    = high_q;
    cfg_new   = '0;
`endif
    wrap      = (count_q == div_q - 1'b1);
    apply     = pend_q & (wrap | ~en_i);
    count_inc = wrap ? '0 : count_q + 1'b1;

    // acc_i is only asserted while not pending, so it never collides with apply.
    if (acc_i) begin
      div_sh_d = CNT_W'(clamp_div(CNT_W_DEF'(div_i)));
`ifdef CLK_GEN_DUTY_EN
      high_sh_d = high_i;
`endif
      pend_d = 1'b1;
    end

    if (apply) begin
      div_d  = div_sh_q;
      pend_d = 1'b0;
`ifdef CLK_GEN_DUTY_EN
      cfg_new.div  = CNT_W_DEF'(div_sh_q);
      cfg_new.high = CNT_W_DEF'(high_sh_q);
      cfg_new      = clamp_cfg(cfg_new);
      high_d       = CNT_W'(cfg_new.high);
`endif
    end

`ifdef CLK_GEN_DUTY_EN
    high_act = high_d;
`else
    high_act = div_d >> 1;
`endif

    // A running apply only happens on wrap, so count_inc is already 0 then.
    if (en_i) begin
      count_d   = count_inc;
      clk_out_d = (count_inc < high_act);
      tick_d    = (count_inc == '0);
    end else begin
      count_d = div_d - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= DIV_RST - 1'b1;
      div_q     <= DIV_RST;
      div_sh_q  <= DIV_RST;
      pend_q    <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
`ifdef CLK_GEN_DUTY_EN
      high_q    <= HIGH_RST;
      high_sh_q <= HIGH_RST;
`endif
    end else begin
      count_q   <= count_d;
      div_q     <= div_d;
      div_sh_q  <= div_sh_d;
      pend_q    <= pend_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
`ifdef CLK_GEN_DUTY_EN
      high_q    <= high_d;
      high_sh_q <= high_sh_d;
`endif
    end
  end

  assign pend_o    = pend_q;
  assign clk_out_o = clk_out_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/clk_gen_multi.sv
// Multi-channel programmable clock/tick generator with glitch-free divisor updates.
// Define CLK_GEN_DUTY_EN to add the cfg_high port and programmable duty per channel.
module clk_gen_multi
  import clk_gen_pkg::*;
#(
  parameter int          CHANNELS    = 4,
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = 50000000,
  localparam int         CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [CNT_W-1:0]    cfg_div,
`ifdef CLK_GEN_DUTY_EN
  input  logic [CNT_W-1:0]    cfg_high,
`endif
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick
);

  logic [CHANNELS-1:0] pend;
  logic [CHANNELS-1:0] acc;

  // Unmatched (out-of-range) channel numbers stay ready and the write is dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_ch == CH_W'(i))
        cfg_ready = ~pend[i];
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    assign acc[g] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(g));

    clk_gen_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .en_i      (en[g]),
      .acc_i     (acc[g]),
      .div_i     (cfg_div),
`ifdef CLK_GEN_DUTY_EN
      .high_i    (cfg_high),
`endif
      .pend_o    (pend[g]),
      .clk_out_o (clk_out[g]),
      .tick_o    (tick[g])
    );
  end

endmodule

// File: tb/tb_clk_gen_multi.sv
// Directed bench for clk_gen_multi with DEFAULT_DIV = 4 and four channels.
// The duty section is compiled only when CLK_GEN_DUTY_EN is defined.
module tb_clk_gen_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_ch;
  logic [31:0] cfg_div;
`ifdef CLK_GEN_DUTY_EN
  logic [31:0] cfg_high;
`endif
  logic [3:0]  clk_out;
  logic [3:0]  tick;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clk_gen_multi #(
    .CHANNELS    (4),
    .CNT_W       (32),
    .DEFAULT_DIV (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
`ifdef CLK_GEN_DUTY_EN
    .cfg_high  (cfg_high),
`endif
    .clk_out   (clk_out),
    .tick      (tick)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] pat_clk;
    logic [7:0] pat_tick;
    logic [3:0] ec [6];
    logic [3:0] et [6];
    logic [6:0] c2_clk;
    logic [6:0] c2_tick;

    pat_clk  = 8'b0011_0011;
    pat_tick = 8'b0001_0001;
    ec = '{4'hF, 4'h2, 4'h0, 4'hD, 4'hD, 4'h2};
    et = '{4'h0, 4'h0, 4'h0, 4'hD, 4'h0, 4'h2};
    c2_clk  = 7'b100_0111;
    c2_tick = 7'b100_0001;

    rst = 1'b1; en = 4'hF; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_div = '0;
`ifdef CLK_GEN_DUTY_EN
    cfg_high = '0;
`endif
    step(); step();
    rst = 1'b0;
    chk("rst_clk_out", 32'(clk_out), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_ready", 32'(cfg_ready), 32'h1);

    // Default divisor 4: 1,1,0,0 on every channel, tick at the start of high.
    for (int k = 0; k < 8; k++) begin
      step();
      chk("def_clk", 32'(clk_out), {28'h0, {4{pat_clk[k]}}});
      chk("def_tick", 32'(tick), {28'h0, {4{pat_tick[k]}}});
    end
    step();
    chk("phase0_clk", 32'(clk_out), 32'hF);

    // ch1 -> divisor 6 written at phase 0; applies after the 4-cycle period.
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 32'd6;
    chk("div6_ready_before", 32'(cfg_ready), 32'h1);
    step();
    cfg_valid = 1'b0;
    chk("div6_ready_p1", 32'(cfg_ready), 32'h0);
    step();
    chk("div6_ready_p2", 32'(cfg_ready), 32'h0);
    step();
    chk("div6_ready_p3", 32'(cfg_ready), 32'h0);
    chk("div6_clk_p3", 32'(clk_out), 32'h0);
    step();
    chk("div6_apply_clk", 32'(clk_out), 32'hF);
    chk("div6_apply_tick", 32'(tick), 32'hF);
    chk("div6_ready_after", 32'(cfg_ready), 32'h1);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("div6_clk", 32'(clk_out), 32'(ec[k]));
      chk("div6_tick", 32'(tick), 32'(et[k]));
    end

    // ch1 divisor 0 is clamped to 2.
    cfg_valid = 1'b1; cfg_div = 32'd0;
    chk("div0_ready", 32'(cfg_ready), 32'h1);
    step();
    cfg_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("div0_wait_ready", 32'(cfg_ready), 32'h0);
      chk("div0_wait_tick", 32'(tick[1]), 32'h0);
    end
    step();
    chk("div0_apply", 32'({clk_out[1], tick[1], cfg_ready}), 32'b111);
    step();
    chk("div0_low", 32'({clk_out[1], tick[1]}), 32'b00);
    step();
    chk("div0_high", 32'({clk_out[1], tick[1]}), 32'b11);

    // ch1 divisor 1 is clamped to 2 as well.
    cfg_valid = 1'b1; cfg_div = 32'd1;
    step();
    cfg_valid = 1'b0;
    chk("div1_accept_low", 32'({clk_out[1], tick[1]}), 32'b00);
    chk("div1_ready_pend", 32'(cfg_ready), 32'h0);
    step();
    chk("div1_apply", 32'({clk_out[1], tick[1], cfg_ready}), 32'b111);
    step();
    chk("div1_low", 32'({clk_out[1], tick[1]}), 32'b00);
    step();
    chk("div1_high", 32'({clk_out[1], tick[1]}), 32'b11);

    // ch2 disabled for 10 cycles; divisor 6 written while disabled applies next edge.
    en[2] = 1'b0;
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 32'd6;
    chk("dis_ready", 32'(cfg_ready), 32'h1);
    step();
    cfg_valid = 1'b0;
    chk("dis_pend", 32'(cfg_ready), 32'h0);
    chk("dis_out0", 32'({clk_out[2], tick[2]}), 32'b00);
    step();
    chk("dis_applied", 32'(cfg_ready), 32'h1);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("dis_out", 32'({clk_out[2], tick[2]}), 32'b00);
    end
    en[2] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step();
      chk("reen_clk", 32'(clk_out[2]), 32'(c2_clk[k]));
      chk("reen_tick", 32'(tick[2]), 32'(c2_tick[k]));
    end

`ifdef CLK_GEN_DUTY_EN
    begin
      logic [31:0] hi_in [3];
      logic [31:0] hi_exp [3];
      int highs;
      int ticks;
      hi_in  = '{32'd3, 32'd0, 32'd12};
      hi_exp = '{32'd3, 32'd1, 32'd9};
      for (int j = 0; j < 3; j++) begin
        en[0] = 1'b0;
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 32'd10; cfg_high = hi_in[j];
        step();
        cfg_valid = 1'b0;
        step();
        en[0] = 1'b1;
        highs = 0; ticks = 0;
        for (int k = 0; k < 10; k++) begin
          step();
          highs += int'(clk_out[0]);
          ticks += int'(tick[0]);
        end
        chk("duty_high", 32'(highs), hi_exp[j]);
        chk("duty_ticks", 32'(ticks), 32'd1);
      end
    end
`endif

    // Reset while ch3 holds a pending divisor 8.
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 32'd8;
    chk("rst_pend_ready", 32'(cfg_ready), 32'h1);
    step();
    cfg_valid = 1'b0;
    chk("rst_pend_set", 32'(cfg_ready), 32'h0);
    rst = 1'b1;
    #1;
    chk("rst_async_out", 32'({clk_out, tick}), 32'h0);
    chk("rst_async_ready", 32'(cfg_ready), 32'h1);
    step();
    rst = 1'b0;
    en = 4'hF;
    chk("rst_rel_ready", 32'(cfg_ready), 32'h1);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("post_rst_clk", 32'(clk_out), {28'h0, {4{pat_clk[k]}}});
      chk("post_rst_tick", 32'(tick), {28'h0, {4{pat_tick[k]}}});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
